// File: rtl/mem_arbiter_if.sv
// Request/response bundle for one memory port: val/rdy request channel plus val/rdy response.
// A requester uses the master modport; whoever serves the requests uses the slave modport.
interface mem_arbiter_if;
  logic        req_val;
  logic        req_rdy;
  logic        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;

  modport master (
    output req_val, req_type, req_addr, req_wdata, resp_rdy,
    input  req_rdy, resp_val, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_val, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an instruction port (port0)
// and a data port (port1), with one transaction outstanding and a buffered response.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  port0,
  mem_arbiter_if.slave  port1,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic grant_val;
  logic winner;

  // With both ports valid the one not granted last time wins.
  assign grant_val = port0.req_val | port1.req_val;
  assign winner    = (port0.req_val & port1.req_val) ? ~last_q : port1.req_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    resp_data_d     = resp_data_q;
    port0.req_rdy   = 1'b0;
    port1.req_rdy   = 1'b0;
    port0.resp_val  = 1'b0;
    port0.resp_data = '0;
    port1.resp_val  = 1'b0;
    port1.resp_data = '0;
    mem.req_val     = 1'b0;
    mem.req_type    = 1'b0;
    mem.req_addr    = '0;
    mem.req_wdata   = '0;
    mem.resp_rdy    = 1'b1;

    case (state_q)
      StIdle: begin
        mem.req_val = grant_val;
        if (grant_val) begin
          if (winner) begin
            mem.req_type  = port1.req_type;
            mem.req_addr  = port1.req_addr;
            mem.req_wdata = port1.req_wdata;
          end else begin
            mem.req_type  = port0.req_type;
            mem.req_addr  = port0.req_addr;
            mem.req_wdata = port0.req_wdata;
          end
        end
        port0.req_rdy = grant_val & ~winner & mem.req_rdy;
        port1.req_rdy = grant_val & winner & mem.req_rdy;
        if (grant_val && mem.req_rdy) begin
          owner_d = winner;
          last_d  = winner;
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem.resp_val) begin
          resp_data_d = mem.resp_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (owner_q) begin
          port1.resp_val  = 1'b1;
          port1.resp_data = resp_data_q;
          if (port1.resp_rdy) state_d = StIdle;
        end else begin
          port0.resp_val  = 1'b1;
          port0.resp_data = resp_data_q;
          if (port0.resp_rdy) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge, outputs are
// checked a little later in the same cycle, well away from the next edge.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if p0 ();
  mem_arbiter_if p1 ();
  mem_arbiter_if mem ();

  mem_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .port0 (p0),
    .port1 (p1),
    .mem   (mem)
  );

  int n_checks;
  int n_errors;
  int n_accepts;
  bit mem_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; in auto mode the memory answers an accepted request the next cycle.
  task automatic next();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = mem.req_val && mem.req_rdy;
    acc_addr = mem.req_addr;
    if (acc) n_accepts++;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      mem.resp_val  = acc;
      mem.resp_data = acc ? mem_word(acc_addr) : 32'h0;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst          = 1'b0;
    p0.req_val   = 1'b0;
    p0.req_type  = 1'b0;
    p0.req_addr  = '0;
    p0.req_wdata = '0;
    p0.resp_rdy  = 1'b1;
    p1.req_val   = 1'b0;
    p1.req_type  = 1'b0;
    p1.req_addr  = '0;
    p1.req_wdata = '0;
    p1.resp_rdy  = 1'b1;
    mem.req_rdy  = 1'b0;
    mem.resp_val = 1'b0;
    mem.resp_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_accepts = 0;
    mem_auto  = 1'b0;
    reset_dut();

    check("rst_resp0_val", p0.resp_val, 0);
    check("rst_resp1_val", p1.resp_val, 0);
    check("rst_resp0_data", p0.resp_data, 0);
    check("rst_memreq_val", mem.req_val, 0);
    check("rst_memreq_addr", mem.req_addr, 0);

    // Single read from port 0 with a hand-driven memory response.
    p0.req_val = 1'b1; p0.req_type = 1'b0; p0.req_addr = 32'h100;
    mem.req_rdy = 1'b1;
    #1;
    check("rd_req0_rdy", p0.req_rdy, 1);
    check("rd_memreq_addr", mem.req_addr, 32'h100);
    next();
    p0.req_val = 1'b0;
    mem.resp_val = 1'b1; mem.resp_data = 32'hDEAD_BEEF;
    #1;
    check("rd_wait_req0_rdy", p0.req_rdy, 0);
    check("rd_wait_resp0_val", p0.resp_val, 0);
    next();
    mem.resp_val = 1'b0; mem.resp_data = '0;
    #1;
    check("rd_resp0_val", p0.resp_val, 1);
    check("rd_resp0_data", p0.resp_data, 32'hDEAD_BEEF);
    check("rd_resp1_val", p1.resp_val, 0);
    next();
    check("rd_idle_resp0_val", p0.resp_val, 0);
    check("rd_idle_resp0_data", p0.resp_data, 0);

    // Contention from reset: grants must alternate 0,1,0,1.
    reset_dut();
    mem_auto = 1'b1;
    mem.req_rdy = 1'b1;
    p0.req_val = 1'b1; p0.req_addr = 32'h200;
    p1.req_val = 1'b1; p1.req_addr = 32'h300;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2) == 1;
      check("rr_req0_rdy", p0.req_rdy, !exp1);
      check("rr_req1_rdy", p1.req_rdy, exp1);
      next();
      check("rr_wait_memreq_val", mem.req_val, 0);
      next();
      if (exp1) begin
        check("rr_resp1_val", p1.resp_val, 1);
        check("rr_resp1_data", p1.resp_data, mem_word(32'h300));
        check("rr_resp0_val", p0.resp_val, 0);
      end else begin
        check("rr_resp0_val", p0.resp_val, 1);
        check("rr_resp0_data", p0.resp_data, mem_word(32'h200));
        check("rr_resp1_val", p1.resp_val, 0);
      end
      next();
    end

    // Memory backpressure on a port-1 write.
    p0.req_val = 1'b0;
    p1.req_val = 1'b1; p1.req_type = 1'b1; p1.req_addr = 32'h40; p1.req_wdata = 32'h1234;
    mem.req_rdy = 1'b0;
    n_accepts = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req1_rdy", p1.req_rdy, 0);
      check("bp_memreq_val", mem.req_val, 1);
      check("bp_memreq_type", mem.req_type, 1);
      check("bp_memreq_addr", mem.req_addr, 32'h40);
      check("bp_memreq_wdata", mem.req_wdata, 32'h1234);
      next();
    end
    mem.req_rdy = 1'b1;
    #1;
    check("bp_req1_rdy_go", p1.req_rdy, 1);
    next();
    p1.req_val = 1'b0; p1.req_type = 1'b0;
    next();
    check("bp_resp1_val", p1.resp_val, 1);
    check("bp_resp1_data", p1.resp_data, mem_word(32'h40));
    next();
    check("bp_accepts", n_accepts, 1);

    // Response backpressure on port 0 with port 1 waiting.
    p0.req_val = 1'b1; p0.req_addr = 32'h500;
    p1.req_val = 1'b1; p1.req_addr = 32'h600;
    #1;
    check("rb_req0_rdy", p0.req_rdy, 1);
    next();
    p0.req_val = 1'b0; p0.resp_rdy = 1'b0;
    next();
    for (int i = 0; i < 5; i++) begin
      check("rb_resp0_val", p0.resp_val, 1);
      check("rb_resp0_data", p0.resp_data, mem_word(32'h500));
      check("rb_memreq_val", mem.req_val, 0);
      check("rb_req1_rdy", p1.req_rdy, 0);
      next();
    end
    p0.resp_rdy = 1'b1;
    #1;
    check("rb_resp0_val_last", p0.resp_val, 1);
    next();
    check("rb_req1_rdy_idle", p1.req_rdy, 1);
    check("rb_memreq_addr", mem.req_addr, 32'h600);
    next();
    p1.req_val = 1'b0;
    next();
    check("rb_resp1_data", p1.resp_data, mem_word(32'h600));
    next();

    // Stray memory response in IDLE.
    mem_auto = 1'b0;
    mem.resp_val = 1'b1; mem.resp_data = 32'hFFFF_FFFF;
    #1;
    check("st_resp0_val", p0.resp_val, 0);
    check("st_resp1_val", p1.resp_val, 0);
    next();
    mem.resp_val = 1'b0; mem.resp_data = '0;
    #1;
    check("st_resp0_val_after", p0.resp_val, 0);
    check("st_resp1_val_after", p1.resp_val, 0);
    p0.req_val = 1'b1; p0.req_type = 1'b0; p0.req_addr = 32'h700;
    #1;
    check("st_req0_rdy", p0.req_rdy, 1);
    next();
    p0.req_val = 1'b0;
    mem.resp_val = 1'b1; mem.resp_data = 32'h7070_7070;
    next();
    mem.resp_val = 1'b0; mem.resp_data = '0;
    #1;
    check("st_resp0_val_rd", p0.resp_val, 1);
    check("st_resp0_data_rd", p0.resp_data, 32'h7070_7070);
    next();

    // Asynchronous reset while waiting on memory; last grant was port 0.
    p0.req_val = 1'b1; p0.req_addr = 32'h800;
    #1;
    check("ar_req0_rdy", p0.req_rdy, 1);
    next();
    p1.req_val = 1'b1; p1.req_addr = 32'h900;
    #1;
    check("ar_wait_memreq_val", mem.req_val, 0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_rst_memreq_val", mem.req_val, 1);
    check("ar_rst_req0_rdy", p0.req_rdy, 1);
    check("ar_rst_req1_rdy", p1.req_rdy, 0);
    check("ar_rst_resp0_val", p0.resp_val, 0);
    mem.resp_val = 1'b1; mem.resp_data = 32'h0000_0BAD;
    next();
    rst = 1'b1;
    mem.req_rdy = 1'b0;
    #1;
    check("ar_rel_memreq_addr", mem.req_addr, 32'h800);
    next();
    mem.resp_val = 1'b0; mem.resp_data = '0;
    #1;
    check("ar_stray_resp0_val", p0.resp_val, 0);
    check("ar_stray_resp1_val", p1.resp_val, 0);
    check("ar_idle_memreq_addr", mem.req_addr, 32'h800);
    mem.req_rdy = 1'b1;
    #1;
    check("ar_first_req0_rdy", p0.req_rdy, 1);
    check("ar_first_req1_rdy", p1.req_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares one single-ported memory between the TinyRV1 pipeline's instruction-fetch port (port 0) and data-memory port (port 1). It accepts val/rdy requests from both ports, grants one at a time round-robin, and issues the winner to the memory. It allows one transaction outstanding, holds the memory response in a register, and returns it to the owning port. It sits between the processor's imem/dmem interfaces and the shared memory model.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- reqN_val  input  1  port N request valid (N = 0, 1)
- reqN_rdy  output  1  port N request accepted this cycle
- reqN_type  input  1  0 = read, 1 = write
- reqN_addr  input  32  byte address
- reqN_wdata  input  32  write data; ignored for reads
- respN_val  output  1  port N response valid
- respN_rdy  input  1  port N can take its response
- respN_data  output  32  read data, or the memory's returned word for a write
- memreq_val  output  1  request to memory valid
- memreq_rdy  input  1  memory accepts request
- memreq_type, memreq_addr, memreq_wdata  output  1/32/32  request fields of the granted port
- memresp_val  input  1  memory response valid; memory always accepts responses
- memresp_data  input  32  memory response data

## Operation
- State machine: IDLE, WAIT, RESP. State resets to IDLE.
- `owner` register (1 bit) records the port of the transaction in flight. `last` register (1 bit) records the last granted port; it resets to 1 so port 0 wins first.
- IDLE grant, combinational:
  - Only one port valid: that port wins.
  - Both valid: the port != `last` wins.
  - Neither valid: no grant.
- IDLE outputs:
  - memreq_val = req0_val | req1_val.
  - memreq_* fields are muxed from the winning port; they are 0 when there is no grant.
  - reqN_rdy = (winner == N) & memreq_rdy. The loser's rdy is 0.
- On memreq_val & memreq_rdy in IDLE: owner <= winner, last <= winner, state -> WAIT.
- If memreq_rdy = 0, nothing is latched. Arbitration is re-evaluated next cycle from the then-current valids, so the grant is not sticky.
- WAIT:
  - All reqN_rdy = 0 and memreq_val = 0.
  - On memresp_val: resp_data register <= memresp_data, state -> RESP.
- RESP:
  - resp{owner}_val = 1 and resp{owner}_data = resp_data register. The other port's resp_val = 0.
  - On resp{owner}_rdy: state -> IDLE.
  - reqN_rdy = 0 and memreq_val = 0.
- memresp_val in IDLE or RESP is ignored and does not change state or resp_data.
- respN_data reads 0 whenever respN_val = 0.
- Writes follow the same path; the port receives one response per accepted write.

## Timing
- Reset values:
  - state IDLE, owner 0, last 1, resp_data 0.
  - respN_val 0, respN_data 0, and memreq fields 0 when no request is valid.
  - reqN_rdy and memreq_val are driven combinationally and follow the request inputs once reset deasserts.
- Reset mid-transaction discards the outstanding request and the buffered response. After reset, memresp_val is ignored until a new request is issued.
- Latency, with the request accepted in cycle 0:
  - Earliest memresp_val is in cycle 1.
  - respN_val rises in cycle 2.
  - With respN_rdy = 1, IDLE is re-entered in cycle 3, where the next request can be accepted.
  - Peak throughput is one transaction per 3 cycles.
- Round-robin fairness: with both ports continuously valid, grants alternate 0,1,0,1…
- Response backpressure: respN_val and respN_data hold steady while respN_rdy = 0; no new memory request is issued meanwhile.
- A port may hold reqN_val while its response is pending. It is arbitrated again only after the FSM returns to IDLE.

## Test plan
- Single read: after reset, req0 read addr 0x100, memreq_rdy = 1, memresp_data = 0xDEADBEEF one cycle later. Required: req0_rdy = 1 in cycle 0; resp0_val = 1 with data 0xDEADBEEF in cycle 2; resp1_val stays 0.
- Contention: req0 and req1 both valid and held for 4 transactions, responses immediate. Required: grant order 0,1,0,1; each respN_data matches that port's address-tagged memory data.
- Memory backpressure: req1 write addr 0x40 wdata 0x1234 with memreq_rdy = 0 for 3 cycles, then 1. Required: req1_rdy = 0 for those 3 cycles; memreq_addr = 0x40 and memreq_wdata = 0x1234 held throughout; exactly one accept.
- Response backpressure: resp0_rdy = 0 for 5 cycles after resp0_val rises, with req1_val = 1 throughout. Required: resp0_data stable; memreq_val = 0 and req1_rdy = 0 until resp0_rdy = 1; req1 granted in the next IDLE cycle.
- Stray response: pulse memresp_val in IDLE with memresp_data = 0xFFFFFFFF. Required: no respN_val and resp_data unchanged; a following read returns its own data.
- Async reset in WAIT: assert rst = 0 mid-cycle. Required: state IDLE and respN_val 0 immediately, with no clock edge. After release, the first grant goes to port 0 when both ports are valid.
